// File: rtl/bp_be_pkg.sv
// Shared BE definitions: issue-queue sizing, queue entry layout, RV64 opcodes and predecode sets.
// Pure declarations; no timing or flow control here.
package bp_be_pkg;

  localparam int vaddr_width_gp     = 64;
  localparam int issue_queue_els_gp = 2;

  localparam logic [6:0] rv64_load_op      = 7'b0000011;
  localparam logic [6:0] rv64_store_op     = 7'b0100011;
  localparam logic [6:0] rv64_op_op        = 7'b0110011;
  localparam logic [6:0] rv64_op_32_op     = 7'b0111011;
  localparam logic [6:0] rv64_op_imm_op    = 7'b0010011;
  localparam logic [6:0] rv64_op_imm_32_op = 7'b0011011;
  localparam logic [6:0] rv64_jalr_op      = 7'b1100111;
  localparam logic [6:0] rv64_jal_op       = 7'b1101111;
  localparam logic [6:0] rv64_branch_op    = 7'b1100011;
  localparam logic [6:0] rv64_lui_op       = 7'b0110111;
  localparam logic [6:0] rv64_auipc_op     = 7'b0010111;
  localparam logic [6:0] rv64_system_op    = 7'b1110011;

  typedef struct packed {
    logic [31:0]               instr;
    logic [vaddr_width_gp-1:0] pc;
  } bp_be_issue_entry_s;

  function automatic logic pd_rs1_used(input logic [6:0] op);
    return op inside {rv64_op_op, rv64_op_32_op, rv64_op_imm_op, rv64_op_imm_32_op,
                      rv64_jalr_op, rv64_branch_op, rv64_load_op, rv64_store_op};
  endfunction

  function automatic logic pd_rs2_used(input logic [6:0] op);
    return op inside {rv64_op_op, rv64_op_32_op, rv64_branch_op, rv64_store_op};
  endfunction

  function automatic logic pd_rd_written(input logic [6:0] op);
    return op inside {rv64_op_op, rv64_op_32_op, rv64_op_imm_op, rv64_op_imm_32_op,
                      rv64_lui_op, rv64_auipc_op, rv64_jal_op, rv64_jalr_op,
                      rv64_load_op, rv64_system_op};
  endfunction

endpackage

// File: rtl/bp_be_issue_scheduler_if.sv
// FE-to-decoder issue bus; slave is the scheduler, master is the FE/pipe side.
// Outputs of the scheduler are combinational from its state plus stall/flush.
interface bp_be_issue_scheduler_if
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p = vaddr_width_gp
);
  logic                     fe_instr_v_i;
  logic [31:0]              fe_instr_i;
  logic [vaddr_width_p-1:0] fe_pc_i;
  logic                     fe_ready_o;
  logic                     mem_stall_i;
  logic                     flush_i;
  logic                     issue_v_o;
  logic [31:0]              issue_instr_o;
  logic [vaddr_width_p-1:0] issue_pc_o;
  logic                     fe_nop_v_o;
  logic                     be_nop_v_o;
  logic                     me_nop_v_o;

  modport master (
    output fe_instr_v_i, fe_instr_i, fe_pc_i, mem_stall_i, flush_i,
    input  fe_ready_o, issue_v_o, issue_instr_o, issue_pc_o,
           fe_nop_v_o, be_nop_v_o, me_nop_v_o
  );

  modport slave (
    input  fe_instr_v_i, fe_instr_i, fe_pc_i, mem_stall_i, flush_i,
    output fe_ready_o, issue_v_o, issue_instr_o, issue_pc_o,
           fe_nop_v_o, be_nop_v_o, me_nop_v_o
  );
endinterface

// File: rtl/bp_be_issue_scoreboard.sv
// Per-register pending-load countdown (x1..x31); pending flags are combinational, updates take 1 cycle.
// freeze holds all counters; clear wins over set, set wins over decrement.
module bp_be_issue_scoreboard (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_v,
  input  logic [4:0] set_addr,
  input  logic [2:0] set_val,
  input  logic       freeze,
  input  logic       clear,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic [4:0] rd_addr,
  output logic       rs1_pending,
  output logic       rs2_pending,
  output logic       rd_pending
);

  logic [2:0] cnt [32];

  // Entry 0 is tied to zero so x0 never reports pending.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (reset || clear || (i == 0)) begin
        cnt[i] <= '0;
      end else if (set_v && (set_addr == 5'(i))) begin
        cnt[i] <= set_val;
      end else if (!freeze && (cnt[i] != '0)) begin
        cnt[i] <= cnt[i] - 3'd1;
      end
    end
  end

  assign rs1_pending = (cnt[rs1_addr] != '0);
  assign rs2_pending = (cnt[rs2_addr] != '0);
  assign rd_pending  = (cnt[rd_addr]  != '0);

endmodule

// File: rtl/bp_be_issue_scheduler.sv
// 2-entry issue queue + load scoreboard feeding the BE decoder; min 1 cycle enqueue-to-issue, no bypass.
// Priority flush > mem stall > hazard > empty > issue; optional perf counters under BP_BE_ISSUE_PERF_EN.
module bp_be_issue_scheduler
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p  = vaddr_width_gp,
  parameter int load_latency_p = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  bp_be_issue_scheduler_if.slave     io
`ifdef BP_BE_ISSUE_PERF_EN
  ,
  output logic [31:0]                perf_issue_cnt_o,
  output logic [31:0]                perf_be_bubble_cnt_o,
  output logic [31:0]                perf_me_bubble_cnt_o
`endif
);

  localparam logic [2:0] load_set_val = 3'(load_latency_p - 1);

  bp_be_issue_entry_s q [issue_queue_els_gp];
  bp_be_issue_entry_s new_entry;
  logic [1:0]         count;
  logic               head_v;
  logic               fe_ready, enq, deq, wr_idx;
  logic               issue, fe_nop, be_nop, me_nop;
  logic [6:0]         head_op;
  logic [4:0]         head_rs1, head_rs2, head_rd;
  logic               rs1_pending, rs2_pending, rd_pending, hazard;
  logic               set_v;
  logic [vaddr_width_p-1:0] head_pc;

  assign head_v    = (count != '0);
  assign head_op   = q[0].instr[6:0];
  assign head_rd   = q[0].instr[11:7];
  assign head_rs1  = q[0].instr[19:15];
  assign head_rs2  = q[0].instr[24:20];
  assign head_pc   = q[0].pc;
  assign new_entry = '{instr: io.fe_instr_i, pc: io.fe_pc_i};

  assign hazard = head_v & ((pd_rs1_used(head_op)   & rs1_pending)
                          | (pd_rs2_used(head_op)   & rs2_pending)
                          | (pd_rd_written(head_op) & rd_pending));

  always_comb begin
    fe_ready = (count < 2'(issue_queue_els_gp)) & ~reset_i;
    issue    = 1'b0;
    fe_nop   = 1'b0;
    be_nop   = 1'b0;
    me_nop   = 1'b0;
    if (!reset_i) begin
      if (io.flush_i)          be_nop = 1'b1;
      else if (io.mem_stall_i) me_nop = 1'b1;
      else if (hazard)         be_nop = 1'b1;
      else if (!head_v)        fe_nop = 1'b1;
      else                     issue  = 1'b1;
    end
  end

  assign enq    = io.fe_instr_v_i & fe_ready & ~io.flush_i;
  assign deq    = issue;
  // Enqueue only happens with count<2, so the slot is 0 or 1.
  assign wr_idx = count[0] & ~deq;

  always_ff @(posedge clk_i) begin
    if (reset_i || io.flush_i) count <= '0;
    else                       count <= count + {1'b0, enq} - {1'b0, deq};
  end

  always_ff @(posedge clk_i) begin
    if (deq) q[0] <= q[1];
    if (enq) q[wr_idx] <= new_entry;
  end

  assign set_v = issue & (head_op == rv64_load_op) & (head_rd != '0);

  bp_be_issue_scoreboard sb (
    .clk         (clk_i),
    .reset       (reset_i),
    .set_v       (set_v),
    .set_addr    (head_rd),
    .set_val     (load_set_val),
    .freeze      (io.mem_stall_i),
    .clear       (io.flush_i),
    .rs1_addr    (head_rs1),
    .rs2_addr    (head_rs2),
    .rd_addr     (head_rd),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .rd_pending  (rd_pending)
  );

  assign io.fe_ready_o    = fe_ready;
  assign io.issue_v_o     = issue;
  assign io.fe_nop_v_o    = fe_nop;
  assign io.be_nop_v_o    = be_nop;
  assign io.me_nop_v_o    = me_nop;
  assign io.issue_instr_o = head_v ? q[0].instr : '0;
  assign io.issue_pc_o    = head_v ? head_pc : '0;

`ifdef BP_BE_ISSUE_PERF_EN
  logic [31:0] perf_issue, perf_be, perf_me;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_issue <= '0;
      perf_be    <= '0;
      perf_me    <= '0;
    end else begin
      if (issue  && (perf_issue != '1)) perf_issue <= perf_issue + 32'd1;
      if (be_nop && (perf_be    != '1)) perf_be    <= perf_be    + 32'd1;
      if (me_nop && (perf_me    != '1)) perf_me    <= perf_me    + 32'd1;
    end
  end

  assign perf_issue_cnt_o     = perf_issue;
  assign perf_be_bubble_cnt_o = perf_be;
  assign perf_me_bubble_cnt_o = perf_me;
`endif

endmodule

// File: tb/tb_bp_be_issue_scheduler.sv
// Directed bench: per-cycle output class checks plus a queue of expected issued instr/pc.
module tb_bp_be_issue_scheduler;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_be_issue_scheduler_if #(.vaddr_width_p(64)) bus ();
  bp_be_issue_scheduler_if #(.vaddr_width_p(64)) bus1 ();

  assign bus1.fe_instr_v_i = bus.fe_instr_v_i;
  assign bus1.fe_instr_i   = bus.fe_instr_i;
  assign bus1.fe_pc_i      = bus.fe_pc_i;
  assign bus1.mem_stall_i  = bus.mem_stall_i;
  assign bus1.flush_i      = bus.flush_i;

`ifdef BP_BE_ISSUE_PERF_EN
  logic [31:0] pi0, pb0, pm0, pi1, pb1, pm1;
`endif

  bp_be_issue_scheduler #(.vaddr_width_p(64), .load_latency_p(3)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .io      (bus)
`ifdef BP_BE_ISSUE_PERF_EN
    , .perf_issue_cnt_o(pi0), .perf_be_bubble_cnt_o(pb0), .perf_me_bubble_cnt_o(pm0)
`endif
  );

  bp_be_issue_scheduler #(.vaddr_width_p(64), .load_latency_p(1)) dut1 (
    .clk_i   (clk),
    .reset_i (reset),
    .io      (bus1)
`ifdef BP_BE_ISSUE_PERF_EN
    , .perf_issue_cnt_o(pi1), .perf_be_bubble_cnt_o(pb1), .perf_me_bubble_cnt_o(pm1)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  logic [63:0] pc_n;

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [3:0] code_vec(input byte c);
    case (c)
      "I":     return 4'b1000;
      "F":     return 4'b0100;
      "B":     return 4'b0010;
      "M":     return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fe(input logic [31:0] ins);
    bus.fe_instr_v_i = 1'b1;
    bus.fe_instr_i   = ins;
    bus.fe_pc_i      = pc_n;
    exp_q.push_back('{ins, pc_n});
    pc_n += 64'd4;
  endtask

  task automatic fe_drop(input logic [31:0] ins);
    bus.fe_instr_v_i = 1'b1;
    bus.fe_instr_i   = ins;
    bus.fe_pc_i      = 64'hdead_0000;
  endtask

  task automatic tick(input byte e, input int rdy = -1, input byte e1 = "-",
                      input logic [31:0] i1 = '0);
    exp_t x;
    @(negedge clk);
    chk($sformatf("outs_%c", e),
        {bus.issue_v_o, bus.fe_nop_v_o, bus.be_nop_v_o, bus.me_nop_v_o}, code_vec(e));
    if (rdy >= 0) chk("fe_ready", bus.fe_ready_o, rdy[0]);
    if (e == "F") chk("empty_instr", bus.issue_instr_o, 0);
    if (e == "I") begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL sb_underflow: observed issue %0h expected nothing queued", bus.issue_instr_o);
      end else begin
        x = exp_q.pop_front();
        chk("issue_instr", bus.issue_instr_o, x.instr);
        chk("issue_pc", bus.issue_pc_o, x.pc);
      end
    end
    if (e1 != "-") begin
      chk($sformatf("lat1_outs_%c", e1),
          {bus1.issue_v_o, bus1.fe_nop_v_o, bus1.be_nop_v_o, bus1.me_nop_v_o}, code_vec(e1));
      if (e1 == "I") chk("lat1_instr", bus1.issue_instr_o, i1);
    end
    @(posedge clk);
    #1;
    bus.fe_instr_v_i = 1'b0;
    bus.flush_i      = 1'b0;
  endtask

  initial begin
    logic [31:0] addi5, add6_55, ld5, add6_50, ld0, add2_00, ld7, addi7, addi8, addi9;
    addi5   = enc_i(7'h13, 5'd5, 3'd0, 5'd0, 12'd1);
    add6_55 = enc_r(5'd6, 5'd5, 5'd5);
    ld5     = enc_i(7'h03, 5'd5, 3'd3, 5'd1, 12'd0);
    add6_50 = enc_r(5'd6, 5'd5, 5'd0);
    ld0     = enc_i(7'h03, 5'd0, 3'd3, 5'd1, 12'd0);
    add2_00 = enc_r(5'd2, 5'd0, 5'd0);
    ld7     = enc_i(7'h03, 5'd7, 3'd3, 5'd1, 12'd0);
    addi7   = enc_i(7'h13, 5'd7, 3'd0, 5'd0, 12'd3);
    addi8   = enc_i(7'h13, 5'd8, 3'd0, 5'd0, 12'd4);
    addi9   = enc_i(7'h13, 5'd9, 3'd0, 5'd0, 12'd5);

    pc_n             = 64'h0000_0000_8000_0000;
    reset            = 1'b1;
    bus.fe_instr_v_i = 1'b0;
    bus.fe_instr_i   = '0;
    bus.fe_pc_i      = '0;
    bus.mem_stall_i  = 1'b0;
    bus.flush_i      = 1'b0;
    @(posedge clk);
    #1;

    // Reset: everything low, then fe_nop with room in the queue.
    repeat (3) tick("R", 0, "R");
    reset = 1'b0;
    tick("F", 1, "F");

    // Back-to-back ALU, no bubble.
    fe(addi5);   tick("F", 1);
    fe(add6_55); tick("I", 1);
    tick("I", 1);
    tick("F", 1);

    // Load-use: two bubbles at latency 3, none at latency 1.
    fe(ld5);     tick("F", -1, "F");
    fe(add6_50); tick("I", -1, "I", ld5);
    tick("B", -1, "I", add6_50);
    tick("B", -1, "F");
    tick("I", -1, "F");
    tick("F");

    // x0 destination never pending.
    fe(ld0);     tick("F");
    fe(add2_00); tick("I");
    tick("I");
    tick("F");

    // WAW on x7.
    fe(ld7);     tick("F");
    fe(addi7);   tick("I");
    tick("B");
    tick("B");
    tick("I");
    tick("F");

    // mem_stall freezes the load countdown.
    fe(ld5);     tick("F");
    fe(add6_50); tick("I");
    bus.mem_stall_i = 1'b1;
    repeat (4) tick("M");
    bus.mem_stall_i = 1'b0;
    tick("B");
    tick("B");
    tick("I");
    tick("F");

    // Stall outranks an empty queue.
    bus.mem_stall_i = 1'b1;
    tick("M", 1);
    bus.mem_stall_i = 1'b0;

    // Flush with full queue and a load still counting down.
    fe(ld5);     tick("F");
    fe(add6_50); tick("I");
    fe(addi8);   tick("B", 1);
    fe_drop(addi9);
    bus.flush_i = 1'b1;
    exp_q.delete();
    tick("B", 0);
    tick("F", 1);
    fe(add6_50); tick("F");
    tick("I");
    tick("F");

    // Flush outranks stall; a same-cycle enqueue is dropped while ready stays high.
    fe_drop(addi9);
    bus.flush_i     = 1'b1;
    bus.mem_stall_i = 1'b1;
    tick("B", 1);
    bus.mem_stall_i = 1'b0;
    tick("F", 1);
    tick("F", 1);

    chk("sb_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_be_issue_scheduler.md
Name: bp_be_issue_scheduler

Overview:
- Sits between the FE instruction queue and the BE instruction decoder.
- Buffers fetched instructions in a 2-entry queue and tracks pending integer-register writes in a scoreboard.
- Each cycle it either issues one instruction to the decoder or asserts exactly one decoder nop source (fe/be/me) with a defined priority.
- Removes load-use and WAW hazards without forwarding logic downstream.

Parameters:
- vaddr_width_p, 64, PC width.
- load_latency_p, 3, cycles from load issue until its result can be forwarded; legal range 1..7.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- fe_instr_v_i  in  1  FE instruction valid
- fe_instr_i  in  32  RISC-V instruction
- fe_pc_i  in  vaddr_width_p  PC of fe_instr_i
- fe_ready_o  out  1  scheduler accepts the FE instruction this cycle
- mem_stall_i  in  1  memory pipe stall; freezes issue
- flush_i  in  1  kill buffered and in-flight work (mispredict or exception)
- issue_v_o  out  1  issue_instr_o/issue_pc_o are valid this cycle
- issue_instr_o  out  32  instruction to the decoder instr_i
- issue_pc_o  out  vaddr_width_p  PC of the issued instruction
- fe_nop_v_o  out  1  to decoder fe_nop_v_i
- be_nop_v_o  out  1  to decoder be_nop_v_i
- me_nop_v_o  out  1  to decoder me_nop_v_i

Behaviour:
- Clock and reset: single clock clk_i; reset_i is synchronous, active-high.
- Reset state: queue empty; all scoreboard counters 0.
  - While reset_i is high: fe_ready_o=0, issue_v_o=0, all nop outputs 0.
  - First cycle after reset: fe_nop_v_o=1.
- Queue: 2-entry FIFO with registered count.
  - fe_ready_o = (count<2) & ~reset_i.
  - Enqueue when fe_instr_v_i & fe_ready_o. Enqueue and dequeue may occur in the same cycle.
  - An instruction enqueued in cycle N can issue in cycle N+1 at the earliest; there is no bypass.
- Predecode of the queue head (opcode only):
  - rs1 used: OP, OP_32, OP_IMM, OP_IMM_32, JALR, BRANCH, LOAD, STORE.
  - rs2 used: OP, OP_32, BRANCH, STORE.
  - rd written: OP, OP_32, OP_IMM, OP_IMM_32, LUI, AUIPC, JAL, JALR, LOAD, SYSTEM.
  - Unknown opcodes have no hazard and issue normally; the decoder flags them illegal.
- Scoreboard: one 3-bit down-counter per register x1..x31; x0 is never pending.
  - On issue of a LOAD with rd!=0: counter[rd] = load_latency_p-1.
  - Other writers leave the counter at 0.
  - Every cycle with ~mem_stall_i, all nonzero counters decrement.
  - The issue write takes precedence over the decrement for that register.
- Hazard: head valid and any of:
  - rs1 used and counter[rs1]!=0
  - rs2 used and counter[rs2]!=0
  - rd written and counter[rd]!=0 (WAW)
- Output priority each cycle (exactly one of the four outputs is 1 when not in reset):
  1. flush_i: be_nop_v_o=1; queue cleared; all counters cleared; a same-cycle FE enqueue is dropped and fe_ready_o stays as computed.
  2. mem_stall_i: me_nop_v_o=1; no dequeue; counters frozen.
  3. Hazard: be_nop_v_o=1; no dequeue.
  4. Queue empty: fe_nop_v_o=1.
  5. Otherwise: issue_v_o=1, head is dequeued, scoreboard is updated.
- issue_instr_o and issue_pc_o always show the queue head. When the queue is empty they show 0.
- All outputs are combinational from registered state plus mem_stall_i, flush_i and reset_i. There is no combinational path from fe_instr_v_i.
- Load-use penalty: load_latency_p-1 bubbles; 2 with the default.

Optional Feature:
- Macro: BP_BE_ISSUE_PERF_EN.
- When defined, adds output ports:
  - perf_issue_cnt_o (32)
  - perf_be_bubble_cnt_o (32)
  - perf_me_bubble_cnt_o (32)
- Counters are saturating, reset to 0, and increment on issue_v_o, be_nop_v_o and me_nop_v_o respectively.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package bp_be_pkg gains:
  - localparam issue_queue_els_gp=2.
  - Typedef bp_be_issue_entry_s {instr, pc}.
  - Predecode helper constants for the rs1/rs2/rd usage opcode sets, reusing the existing RV64 opcode defines.
- Sub-module bp_be_issue_scoreboard:
  - Holds the 31 counters.
  - Inputs: set_v/set_addr/set_val, freeze, clear.
  - Outputs: the three pending flags for the queried rs1/rs2/rd addresses.

Test Plan:
- Reset: hold reset 3 cycles, all outputs 0 → release; next cycle fe_nop_v_o=1, fe_ready_o=1.
- Back-to-back ALU: enqueue "addi x5,x0,1" then "add x6,x5,x5" → issue_v_o in two consecutive cycles, no be_nop.
- Load-use: "ld x5,0(x1)" then "add x6,x5,x0" → ld issues, then be_nop_v_o for 2 cycles, then the add issues. With load_latency_p=1 there are 0 bubbles.
- x0 and WAW: "ld x0,0(x1)" then "add x2,x0,x0" → no bubble. "ld x7" then "addi x7,x0,3" → 2 bubbles.
- mem_stall: assert mem_stall_i for 4 cycles 1 cycle after a load issues → me_nop_v_o=1 for 4 cycles and the counter is frozen at 2. After release, 2 more be_nops occur before the dependent issues.
- Flush with full queue and a pending load: flush_i for 1 cycle → be_nop_v_o=1; next cycle fe_nop_v_o=1, queue empty. A dependent newly enqueued after the flush issues with no bubble.
